// File: rtl/bank_ram_pkg.sv
// rtl/bank_ram_pkg.sv - shared types and sizing helpers for the bank RAM front-end
// Purpose : default RAM geometry, address/data typedefs, packed RAM request
//           struct and the FIFO count-width helper used by the front-end.
// Ports   : none (package)
package bank_ram_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 10;
   localparam int DEFAULT_DATA_WIDTH = 64;

   typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
   typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

   typedef struct packed {
      logic  we;
      addr_t addr;
      data_t wdata;
   } ram_req_t;

   // A count must represent 0..depth inclusive, hence one bit above the pointer.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ram_if.sv
// rtl/ram_if.sv - single-port bank RAM port bundle
// Purpose : groups the RAM command and read-data signals.
// Ports   : en, we, addr, wdata (master -> slave); rdata (slave -> master)
//           master = request controller, slave = RAM macro/model.
interface ram_if
   import bank_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic                  en;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output en,
      output we,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  en,
      input  we,
      input  addr,
      input  wdata,
      output rdata
   );

endinterface

// File: rtl/bank_rsp_fifo.sv
// rtl/bank_rsp_fifo.sv - synchronous response FIFO for bank RAM read data
// Purpose : power-of-2 deep FIFO; push and pop in the same cycle are legal at
//           any occupancy, including full.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           push, din  - write strobe and data
//           pop        - read strobe (ignored when empty)
//           dout       - head entry, zero while empty
//           empty/full - occupancy flags
//           count      - number of entries held (0..DEPTH)
module bank_rsp_fifo
   import bank_ram_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             push_en;
   logic             pop_en;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign pop_en  = pop && !empty;
   // A full FIFO can still take a push when the head leaves in the same cycle:
   // the write lands in the slot being vacated.
   assign push_en = push && (!full || pop_en);

   // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_en, pop_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; validity is carried by count_q.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= din;
      end
   end

   assign dout = empty ? '0 : mem[rd_ptr];

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop));

endmodule

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - single-port RAM with one-cycle registered read
// Purpose : bank RAM behavioural macro; write on en&we, read data registered
//           and updated only on en&!we (holds otherwise).
// Ports   : clk - clock
//           ram - ram_if.slave port (en, we, addr, wdata in; rdata out)
module single_port_ram
   import bank_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic clk,
   ram_if.slave ram
);

   localparam int WORDS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (ram.en) begin
         if (ram.we) begin
            mem[ram.addr] <= ram.wdata;
         end else begin
            rdata_q <= mem[ram.addr];
         end
      end
   end

   assign ram.rdata = rdata_q;

endmodule

// File: rtl/bank_ram_req_ctrl.sv
// rtl/bank_ram_req_ctrl.sv - request/response front-end for one bank RAM
// Purpose : turns a valid/ready request stream into single-port RAM cycles,
//           tracks the read in flight and buffers read data so the consumer
//           may stall; responses return in issue order, writes give none.
// Ports   : clk, rst                        - clock, synchronous active-high reset
//           req_valid/req_ready             - request handshake
//           req_we, req_addr, req_wdata     - request payload (1 = write)
//           rsp_valid/rsp_ready, rsp_rdata  - response handshake and read data
//           ram                             - ram_if.master port to the RAM
module bank_ram_req_ctrl
   import bank_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   ram_if.master                 ram
);

   localparam int CW = cnt_width(RSP_DEPTH);

   logic          fire;
   logic          rd_pend;
   logic          fifo_empty;
   logic          fifo_full;
   logic          fifo_pop;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   outstanding;

   // Every read in flight or already buffered holds a FIFO slot, so a read is
   // only issued when its data is guaranteed a place to land. Only registered
   // state feeds this, keeping rsp_ready and req_valid out of req_ready.
   assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend};
   assign req_ready   = !rst && (outstanding < (CW+1)'(RSP_DEPTH));
   assign fire        = req_valid && req_ready;

   // Zero-latency drive of the RAM port straight from the request.
   assign ram.en    = fire;
   assign ram.we    = req_we;
   assign ram.addr  = req_addr;
   assign ram.wdata = req_wdata;

   // RAM read data is valid the cycle after issue; rd_pend marks that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= fire && !req_we;
      end
   end

   assign fifo_pop  = rsp_valid && rsp_ready;
   assign rsp_valid = !fifo_empty;

   bank_rsp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_pend),
      .pop   (fifo_pop),
      .din   (ram.rdata),
      .dout  (rsp_rdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   a_credit_holds : assert property (@(posedge clk) disable iff (rst)
      !(rd_pend && fifo_full));

endmodule

// File: tb/tb_bank_ram_req_ctrl.sv
// tb/tb_bank_ram_req_ctrl.sv - directed self-checking bench for bank_ram_req_ctrl
module tb_bank_ram_req_ctrl;
   import bank_ram_pkg::*;

   logic  clk = 1'b0;
   logic  rst;
   logic  req_valid;
   logic  req_ready;
   logic  req_we;
   addr_t req_addr;
   data_t req_wdata;
   logic  rsp_valid;
   logic  rsp_ready;
   data_t rsp_rdata;

   int    n_cmp = 0;
   int    n_err = 0;
   data_t ref_mem [int];
   data_t q [$];

   ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) ram_bus ();

   bank_ram_req_ctrl #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (64),
      .RSP_DEPTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram       (ram_bus)
   );

   single_port_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) u_ram (
      .clk (clk),
      .ram (ram_bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no_finish, need finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, need %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request, hold it until accepted, then drop it.
   task automatic do_req(input logic we, input addr_t a, input data_t d);
      bit ok = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (req_ready) begin
            ok = 1;
            break;
         end
         step();
      end
      check("req_accept", 64'(ok), 64'd1);
      if (ok && we) ref_mem[int'(a)] = d;
      step();
      req_valid = 1'b0;
   endtask

   task automatic read_word(input addr_t a, output data_t d);
      bit ok = 0;
      d = '0;
      rsp_ready = 1'b1;
      do_req(1'b0, a, '0);
      for (int k = 0; k < 6; k++) begin
         #1;
         if (rsp_valid) begin
            d  = rsp_rdata;
            ok = 1;
            step();
            break;
         end
         step();
      end
      check("rd_rsp_seen", 64'(ok), 64'd1);
   endtask

   initial begin
      data_t got;
      int    acc;
      int    a;
      bit    fired;
      bit    wr_done;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // ---- reset ----
      step();
      req_valid = 1'b1;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_ram_en", 64'(ram_bus.en), 64'd0);
      step();
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_ready_after", 64'(req_ready), 64'd1);

      // ---- 1: write then read-after-write ----
      step();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 64'hA5A5;
      #1;
      check("t1_wr_en", 64'(ram_bus.en), 64'd1);
      check("t1_wr_we", 64'(ram_bus.we), 64'd1);
      check("t1_wr_addr", 64'(ram_bus.addr), 64'h010);
      check("t1_wr_data", ram_bus.wdata, 64'hA5A5);
      ref_mem[16] = 64'hA5A5;
      step();
      req_we = 1'b0;
      #1;
      check("t1_rd_en", 64'(ram_bus.en), 64'd1);
      check("t1_rd_we", 64'(ram_bus.we), 64'd0);
      step();
      req_valid = 1'b0; rsp_ready = 1'b1;
      #1;
      check("t1_valid_n1", 64'(rsp_valid), 64'd0);
      step();
      check("t1_valid_n2", 64'(rsp_valid), 64'd1);
      check("t1_data_n2", rsp_rdata, 64'hA5A5);
      step();
      check("t1_valid_n3", 64'(rsp_valid), 64'd0);

      // ---- 2: preload and back-to-back reads ----
      for (int i = 0; i < 8; i++) do_req(1'b1, addr_t'(i), data_t'(64'h100 + i));
      rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = addr_t'(c);
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (c < 8) check("t2_ready", 64'(req_ready), 64'd1);
         if (c >= 2 && c <= 9) begin
            check("t2_valid", 64'(rsp_valid), 64'd1);
            check("t2_data", rsp_rdata, 64'h100 + 64'(c - 2));
         end else begin
            check("t2_idle", 64'(rsp_valid), 64'd0);
         end
         step();
      end

      // ---- 3: stalled consumer, credit limit, drain ----
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; acc = 0; a = 0;
      for (int c = 0; c < 8; c++) begin
         req_addr = addr_t'(a);
         #1;
         if (req_ready) begin
            acc++;
            a++;
         end
         if (c >= 6) check("t3_hold_data", rsp_rdata, 64'h100);
         step();
      end
      req_valid = 1'b0;
      #1;
      check("t3_accepted", 64'(acc), 64'd4);
      check("t3_ready_low", 64'(req_ready), 64'd0);
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t3_drain_valid", 64'(rsp_valid), 64'd1);
         check("t3_drain_data", rsp_rdata, 64'h100 + 64'(k));
         step();
      end
      #1;
      check("t3_empty", 64'(rsp_valid), 64'd0);
      check("t3_ready_back", 64'(req_ready), 64'd1);

      // ---- 4: full FIFO, pop and new read pending together ----
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_addr = addr_t'(4 + c);
         #1;
         check("t4_fill_ready", 64'(req_ready), 64'd1);
         step();
      end
      req_valid = 1'b0;
      step();
      q = {};
      rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 10'h000;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (c == 0) begin
            check("t4_full_block", 64'(req_ready), 64'd0);
            check("t4_full_head", rsp_rdata, 64'h104);
         end
         if (rsp_valid) q.push_back(rsp_rdata);
         fired = req_valid && req_ready;
         step();
         if (fired) req_valid = 1'b0;
      end
      check("t4_rsp_count", 64'(q.size()), 64'd5);
      if (q.size() == 5) begin
         check("t4_q0", q[0], 64'h104);
         check("t4_q1", q[1], 64'h105);
         check("t4_q2", q[2], 64'h106);
         check("t4_q3", q[3], 64'h107);
         check("t4_q4", q[4], 64'h100);
      end

      // ---- 5: reset with a read in flight and 2 buffered ----
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h001;
      step();
      req_addr = 10'h002;
      step();
      req_valid = 1'b0;
      step();
      req_valid = 1'b1; req_addr = 10'h003;
      #1;
      check("t5_fire_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0; rst = 1'b1;
      #1;
      check("t5_rst_ready", 64'(req_ready), 64'd0);
      step();
      rst = 1'b0;
      #1;
      check("t5_valid_after", 64'(rsp_valid), 64'd0);
      check("t5_rdata_after", rsp_rdata, 64'd0);
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("t5_no_stale", 64'(rsp_valid), 64'd0);
      end

      // ---- 6: writes against a full FIFO ----
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_addr = addr_t'(c);
         step();
      end
      req_valid = 1'b0;
      step();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h020; req_wdata = 64'hBEEF;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t6_wr_blocked", 64'(req_ready), 64'd0);
         check("t6_wr_no_en", 64'(ram_bus.en), 64'd0);
         step();
      end
      q = {}; wr_done = 0; rsp_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (rsp_valid) q.push_back(rsp_rdata);
         fired = req_valid && req_ready;
         step();
         if (fired) begin
            req_valid = 1'b0;
            wr_done = 1;
            ref_mem[32] = 64'hBEEF;
         end
      end
      check("t6_wr_done", 64'(wr_done), 64'd1);
      check("t6_rsp_count", 64'(q.size()), 64'd4);
      if (q.size() == 4) begin
         for (int k = 0; k < 4; k++) check("t6_drain", q[k], 64'h100 + 64'(k));
      end
      do_req(1'b1, 10'h021, 64'h1234);
      do_req(1'b1, 10'h000, 64'hDEAD);
      read_word(10'h020, got);
      check("t6_mem_020", got, ref_mem[32]);
      read_word(10'h021, got);
      check("t6_mem_021", got, ref_mem[33]);
      read_word(10'h000, got);
      check("t6_mem_000", got, ref_mem[0]);
      read_word(10'h001, got);
      check("t6_mem_001", got, ref_mem[1]);
      read_word(10'h010, got);
      check("t6_mem_010", got, ref_mem[16]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
